// File: rtl/contador_pkg.sv
// Shared types and helpers for the modulo-N down counter.
package contador_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSE,
        DONE
    } cnt_state_t;

    // Out-of-range load values saturate to the top of the count range.
    function automatic int unsigned clamp_load(input int unsigned din, input int unsigned mod_n);
        return (din >= mod_n) ? (mod_n - 1) : din;
    endfunction

endpackage

// File: rtl/contador_regressivo_mod.sv
// Modulo-MOD down counter with load, start/stop, optional auto-reload and a
// registered terminal-count borrow pulse for cascading.
module contador_regressivo_mod
    import contador_pkg::*;
#(
    parameter int MOD = 6,
    parameter int W   = $clog2(MOD)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         stop,
    input  logic         en,
    input  logic         load,
    input  logic [W-1:0] din,
    input  logic         auto_reload,
    output logic [W-1:0] q,
    output logic         tc,
    output logic         done,
    output logic         running
);

    localparam logic [W-1:0] MAXV = W'(MOD - 1);

    cnt_state_t   r_state;
    logic [W-1:0] r_q;
    logic         r_tc;
    logic [W-1:0] w_load_val;
    logic         w_run_edge;

    assign w_load_val = W'(clamp_load(int'(din), MOD));

    // Stop dominates start everywhere; start from IDLE/PAUSE counts on the same edge.
    assign w_run_edge = !stop && ((r_state == RUN) ||
                        (start && ((r_state == IDLE) || (r_state == PAUSE))));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_q     <= MAXV;
            r_tc    <= 1'b0;
        end else begin
            r_tc <= 1'b0;
            if (load) begin
                r_q <= w_load_val;
                if (r_state == DONE) begin
                    r_state <= IDLE;
                end
            end else if ((r_state == RUN) && stop) begin
                r_state <= PAUSE;
            end else if (w_run_edge) begin
                r_state <= RUN;
                if (en) begin
                    if (r_q != '0) begin
                        r_q <= r_q - W'(1);
                    end else if (auto_reload) begin
                        r_q  <= MAXV;
                        r_tc <= 1'b1;
                    end else begin
                        r_state <= DONE;
                        r_tc    <= 1'b1;
                    end
                end
            end
        end
    end

    assign q       = r_q;
    assign tc      = r_tc;
    assign done    = (r_state == DONE);
    assign running = (r_state == RUN);

endmodule

// File: tb/tb_contador_regressivo_mod.sv
// Directed self-checking bench for contador_regressivo_mod (MOD=6, 2, 10).
module tb_contador_regressivo_mod;

    logic       clk = 1'b0;
    logic       rst, start, stop, en, load, auto_reload;
    logic [2:0] din6;
    logic [0:0] din2;
    logic [3:0] din10;
    logic [2:0] q6;
    logic [0:0] q2;
    logic [3:0] q10;
    logic       tc6, done6, run6;
    logic       tc2, done2, run2;
    logic       tc10, done10, run10;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    contador_regressivo_mod #(.MOD(6)) dut6 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .en(en), .load(load),
        .din(din6), .auto_reload(auto_reload), .q(q6), .tc(tc6), .done(done6), .running(run6)
    );

    contador_regressivo_mod #(.MOD(2)) dut2 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .en(en), .load(load),
        .din(din2), .auto_reload(auto_reload), .q(q2), .tc(tc2), .done(done2), .running(run2)
    );

    contador_regressivo_mod #(.MOD(10)) dut10 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .en(en), .load(load),
        .din(din10), .auto_reload(auto_reload), .q(q10), .tc(tc10), .done(done10), .running(run10)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int tcs6, tcs2, tcs10;
        rst = 1'b1; start = 1'b0; stop = 1'b0; en = 1'b0; load = 1'b0;
        auto_reload = 1'b0; din6 = '0; din2 = '0; din10 = '0;

        #2;
        chk("reset_q", int'(q6), 5);
        chk("reset_tc", int'(tc6), 0);
        chk("reset_done", int'(done6), 0);
        chk("reset_running", int'(run6), 0);
        #8 rst = 1'b0;

        // Count to DONE without auto-reload
        start = 1'b1; en = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk("hold_q", int'(q6), 5 - k);
            chk("hold_tc", int'(tc6), 0);
        end
        chk("hold_running", int'(run6), 1);
        tick();
        chk("expire_q", int'(q6), 0);
        chk("expire_tc", int'(tc6), 1);
        chk("expire_done", int'(done6), 1);
        chk("expire_running", int'(run6), 0);
        tick();
        chk("done_tc_low", int'(tc6), 0);
        chk("done_q_hold", int'(q6), 0);
        chk("done_start_ignored", int'(done6), 1);

        // Load in DONE returns to IDLE
        load = 1'b1; din6 = 3'd3;
        tick();
        load = 1'b0; start = 1'b0; en = 1'b0;
        chk("load_done_q", int'(q6), 3);
        chk("load_done_done", int'(done6), 0);
        chk("load_done_running", int'(run6), 0);

        // Auto-reload
        rst = 1'b1; #2 rst = 1'b0;
        auto_reload = 1'b1; start = 1'b1; en = 1'b1;
        tcs6 = 0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk("ar_q", int'(q6), 5 - (k % 6));
            chk("ar_tc", int'(tc6), (k % 6 == 0) ? 1 : 0);
            if (tc6) tcs6++;
        end
        chk("ar_tc_count", tcs6, 2);
        chk("ar_done", int'(done6), 0);

        // Load clamp and priority over decrement
        tick();
        chk("pre_load_q", int'(q6), 4);
        load = 1'b1; din6 = 3'd7;
        tick();
        chk("load_clamp_q", int'(q6), 5);
        chk("load_clamp_running", int'(run6), 1);
        din6 = 3'd2;
        tick();
        chk("load_q2", int'(q6), 2);
        chk("load_tc", int'(tc6), 0);
        din6 = 3'd3;
        tick();
        load = 1'b0;
        chk("load_q3", int'(q6), 3);

        // Stop beats start, then resume
        stop = 1'b1; start = 1'b1;
        tick();
        chk("stop_q", int'(q6), 3);
        chk("stop_running", int'(run6), 0);
        stop = 1'b0; start = 1'b0;
        tick();
        chk("pause_hold_q", int'(q6), 3);
        start = 1'b1;
        tick();
        chk("resume_q", int'(q6), 2);
        chk("resume_running", int'(run6), 1);

        // Asynchronous reset mid-cycle
        #3 rst = 1'b1;
        #1;
        chk("async_q", int'(q6), 5);
        chk("async_tc", int'(tc6), 0);
        chk("async_running", int'(run6), 0);
        chk("async_done", int'(done6), 0);
        #2 rst = 1'b0;

        // Parameter sweep: MOD=2 and MOD=10 in auto-reload
        auto_reload = 1'b1; start = 1'b1; en = 1'b1;
        tcs2 = 0; tcs10 = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (tc2) tcs2++;
            if (tc10) tcs10++;
            if (k == 1) chk("m2_q_k1", int'(q2), 0);
            if (k == 2) chk("m2_q_k2", int'(q2), 1);
            if (k == 9) chk("m10_q_k9", int'(q10), 0);
            if (k == 10) chk("m10_q_k10", int'(q10), 9);
        end
        chk("m2_tc_count", tcs2, 10);
        chk("m10_tc_count", tcs10, 2);
        chk("m10_done", int'(done10), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/contador_regressivo_mod.md
Name: contador_regressivo_mod

Overview:
- Synchronous, parameterised modulo-N down counter (countdown timer); default N=6. It is the down-counting counterpart of the lab's mod-6 up counter.
- Counts MOD-1 → 0 on enabled ticks.
- Supports parallel load, start/stop control, optional auto-reload, and a terminal-count borrow pulse for cascading.
- Used by the FPGA practice tops as a timer stage and as the low digit of cascaded countdowns.

Parameters:
- MOD, 6, counting modulus; count range 0..MOD-1; legal values are MOD ≥ 2.
- W, $clog2(MOD), counter width; derived, not overridden.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  level-sampled; moves IDLE or PAUSE to RUN.
- stop  input  1  level-sampled; moves RUN to PAUSE.
- en  input  1  count tick; one decrement per clk edge where en=1 in RUN.
- load  input  1  synchronous parallel load of din.
- din  input  W  load value; values ≥ MOD are clamped to MOD-1.
- auto_reload  input  1  1 = wrap 0→MOD-1 and keep running; 0 = stop at 0.
- q  output  W  current count, registered.
- tc  output  1  one-cycle borrow pulse, registered.
- done  output  1  high while in DONE.
- running  output  1  high while in RUN.

Behaviour:
- Reset: rst=1 immediately forces q=MOD-1, state=IDLE, tc=0, done=0, running=0, regardless of clk.
- States:
  - IDLE: q holds its value.
  - RUN: q counts down.
  - PAUSE: q holds its value.
  - DONE: q=0 and holds.
- Priority per edge, highest first:
  - load: q←min(din, MOD-1). The state is unchanged, except DONE goes to IDLE. tc=0 that cycle.
  - stop: RUN→PAUSE. Stop wins over a simultaneous start.
  - start: IDLE/PAUSE→RUN. start in DONE is ignored; leave DONE with load.
  - en in RUN: decrement.
- Decrement in RUN with en=1:
  - q>0: q←q-1.
  - q=0 and auto_reload=1: q←MOD-1, stay in RUN, tc=1 in the next cycle.
  - q=0 and auto_reload=0: q stays 0, state→DONE, tc=1 in the next cycle.
- Reaching 0 does not raise tc; only the tick that leaves 0 (or expires at 0) raises tc.
- en outside RUN has no effect. In RUN, en=0 holds q.
- tc is exactly one cycle wide and low in every other cycle.
- running=(state==RUN) and done=(state==DONE), both registered with the state.
- Latency: q changes on the same edge that samples en. Counting begins on the first edge at which both start and en are high.
- load while in RUN with en=1: load wins and no decrement occurs that edge.
- auto_reload is sampled only on the edge where q=0 and en=1.
- Reset asserted mid-count aborts the count: no tc, and the block returns to the reset state.
- Width: all arithmetic is in W bits. The clamp compares din against MOD in W+1 bits.
- No combinational path from any input to any output.

Decomposition:
- Package contador_pkg holds:
  - typedef enum logic [1:0] cnt_state_t {IDLE, RUN, PAUSE, DONE};
  - helper function clamp_load(din, MOD).
- No sub-module.
- Cascading, where the tc of a low digit drives en of the next stage, is done in the practice top, not inside this block.

Test Plan (MOD=6 unless stated):
- Reset then hold: rst pulse, then start=1, en=1 for 6 cycles, auto_reload=0 → q=5,4,3,2,1,0; the next tick leaves q=0, tc=1 for one cycle, done=1, running=0; further en leaves q=0.
- Auto-reload: same as above with auto_reload=1 for 13 ticks → q sequence 5..0,5..0,5; tc pulses exactly twice; done stays 0.
- Load clamp and priority: in RUN, load=1, din=7, en=1 on the same edge → q=5 with no decrement; din=2 → q=2; load in DONE → q=din, state IDLE.
- Start/stop: at q=3, apply stop=1 and start=1 on the same edge → PAUSE, q=3 holds under en; then start alone → RUN and decrement resumes to 2.
- Async reset mid-count: assert rst between clock edges at q=2 → q=5, tc=0, state IDLE immediately, before the next edge.
- Parameter sweep: MOD=2 and MOD=10 (W=1 and W=4) → wrap MOD-1..0, and tc occurs once per MOD ticks in auto-reload.
